exc_arb: RTL

EXC_ARB -- requirements
Module: exc_arb

---
 rtl/exc_arb.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/exc_arb.sv
// exc_arb: MEM-stage exception arbiter. Gathers raw exception flags, the
// synchronized hardware interrupt lines and CP0 Status/Cause. It picks the
// single highest-priority exception code for the CP0 and kills the MEM-stage
// instruction when it faults. A one-cycle BLANK state follows every taken
// exception or ERET, so the redirected pipeline is not re-arbitrated while
// the flush settles.
//
// Ports
//   cpu_clk_50M      in   1   clock, rising edge
//   cpu_rst_n        in   1   synchronous active-low reset
//   mem_valid_i      in   1   MEM slot holds a real instruction
//   mem_pc_i         in  32   PC of the MEM instruction
//   mem_addr_i       in  32   load/store effective address
//   mem_is_branch_i  in   1   MEM instruction is a branch/jump
//   exc_flags_i      in   8   raw exception flags (fetch AdEL .. eret)
//   status_i         in  32   CP0 Status
//   cause_i          in  32   CP0 Cause (soft interrupts in [9:8])
//   ext_int_i        in   6   asynchronous hardware interrupt lines
//   exccode_o        out  5   selected exception code (NONE = 5'h10)
//   pc_o             out 32   EPC candidate
//   in_delay_o       out  1   faulting instruction sits in a delay slot
//   badvaddr_o       out 32   faulting address for AdEL/AdES
//   int_o            out  6   synchronized interrupt lines
//   mem_kill_o       out  1   suppress MEM memory/register writes
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | arbitrate the MEM instruction each cycle
// BLANK | one cycle after an exception/ERET; all sources ignored

module exc_arb (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_is_branch_i,
    input  logic [7:0]  exc_flags_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [5:0]  ext_int_i,
    output logic [4:0]  exccode_o,
    output logic [31:0] pc_o,
    output logic        in_delay_o,
    output logic [31:0] badvaddr_o,
    output logic [5:0]  int_o,
    output logic        mem_kill_o
);

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_NONE = 5'h10;
    localparam logic [4:0] EXC_ERET = 5'h11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic        br_prev, br_prev_nxt;
    logic [5:0]  int_sync1, int_sync2;
    logic        qual;
    logic        int_pend;
    logic        exc_taken;

    // Status/Cause bits the arbiter does not look at.
    logic unused_bits;
    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state     <= ST_RUN;
            br_prev   <= 1'b0;
            int_sync1 <= 6'h0;
            int_sync2 <= 6'h0;
        end else begin
            state     <= state_nxt;
            br_prev   <= br_prev_nxt;
            int_sync1 <= ext_int_i;
            int_sync2 <= int_sync1;
        end
    end

    // Outputs are held at zero combinationally while reset is asserted,
    // independent of what the flops currently hold.
    assign int_o = cpu_rst_n ? int_sync2 : 6'h0;

    always_comb begin
        exccode_o   = EXC_NONE;
        badvaddr_o  = 32'h0;
        state_nxt   = state;
        br_prev_nxt = br_prev;

        qual     = cpu_rst_n & mem_valid_i & (state == ST_RUN);
        int_pend = (|({int_o, cause_i[9:8]} & status_i[15:8])) & status_i[0] & ~status_i[1];

        if (qual) begin
            // The interrupt outranks ERET, so an ERET that coincides with a
            // pending interrupt is replaced by the interrupt.
            if (int_pend) begin
                exccode_o = EXC_INT;
            end else if (exc_flags_i[0]) begin
                exccode_o  = EXC_ADEL;
                badvaddr_o = mem_pc_i;
            end else if (exc_flags_i[1]) begin
                exccode_o = EXC_RI;
            end else if (exc_flags_i[2]) begin
                exccode_o = EXC_OV;
            end else if (exc_flags_i[3]) begin
                exccode_o = EXC_SYS;
            end else if (exc_flags_i[4]) begin
                exccode_o = EXC_BP;
            end else if (exc_flags_i[5]) begin
                exccode_o  = EXC_ADEL;
                badvaddr_o = mem_addr_i;
            end else if (exc_flags_i[6]) begin
                exccode_o  = EXC_ADES;
                badvaddr_o = mem_addr_i;
            end else if (exc_flags_i[7]) begin
                exccode_o = EXC_ERET;
            end
        end

        exc_taken  = (exccode_o != EXC_NONE);
        pc_o       = exc_taken ? mem_pc_i : 32'h0;
        in_delay_o = br_prev & exc_taken;
        mem_kill_o = cpu_rst_n & ((exc_taken & (exccode_o != EXC_ERET)) | (state == ST_BLANK));

        case (state)
            ST_RUN: begin
                if (exc_taken) begin
                    state_nxt   = ST_BLANK;
                    br_prev_nxt = 1'b0;
                end else if (qual) begin
                    br_prev_nxt = mem_is_branch_i;
                end
            end
            ST_BLANK: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

endmodule
